// File: rtl/vga_frame_capture.sv
// vga_frame_capture: measures parallel video timing and captures one frame into a RAM write port.
// Define VGA_CAP_CHECKSUM_EN to add cap_sum, a wrapping 32-bit sum of the captured pixels.
module vga_frame_capture #(
    parameter int MAX_W  = 640,
    parameter int MAX_H  = 480,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vid_hs,
    input  logic              vid_vs,
    input  logic              vid_de,
    input  logic [23:0]       vid_rgb,
    input  logic              cap_req,
    output logic              cap_busy,
    output logic              cap_done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [23:0]       wr_data,
    output logic              meas_valid,
    output logic [11:0]       meas_h_total,
    output logic [11:0]       meas_h_act,
    output logic [11:0]       meas_v_total,
    output logic [11:0]       meas_v_act,
`ifdef VGA_CAP_CHECKSUM_EN
    output logic [31:0]       cap_sum,
`endif
    output logic              overflow
);
    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
    state_t state_q, state_d;
    logic hs_q, vs_q, de_q, hs_p_q, vs_p_q, de_p_q;
    logic [23:0] rgb_q;
    logic hs_fall, vs_fall, de_rise, de_fall;
    logic [11:0] col_q, col_d, row_q, row_d, pix_col, pix_row;
    logic [11:0] h_cnt_q, h_cnt_d, h_tot_q, h_tot_d, h_act_q, h_act_d;
    logic [11:0] v_cnt_q, v_cnt_d, va_cnt_q, va_cnt_d;
    logic seen_vs_q, meas_valid_q, overflow_q, overflow_d;
    logic [11:0] meas_h_total_q, meas_h_act_q, meas_v_total_q, meas_v_act_q;
    logic in_frame, in_bounds, wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [23:0] wr_data_q;

    function automatic logic [11:0] sat_inc(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    assign hs_fall = hs_p_q & ~hs_q;
    assign vs_fall = vs_p_q & ~vs_q;
    assign de_rise = de_q & ~de_p_q;
    assign de_fall = de_p_q & ~de_q;

    // A VS fall that lands on a DE pixel starts the new frame before placing that pixel.
    always_comb begin
        pix_col  = de_rise ? 12'd0 : col_q;
        pix_row  = vs_fall ? 12'd0 : row_q;
        col_d    = de_q ? sat_inc(pix_col) : col_q;
        row_d    = vs_fall ? 12'd0 : de_fall ? sat_inc(row_q) : row_q;
        h_cnt_d  = hs_fall ? 12'd1 : sat_inc(h_cnt_q);
        h_tot_d  = hs_fall ? h_cnt_q : h_tot_q;
        h_act_d  = de_fall ? col_q : h_act_q;
        v_cnt_d  = vs_fall ? {11'd0, hs_fall} : hs_fall ? sat_inc(v_cnt_q) : v_cnt_q;
        va_cnt_d = vs_fall ? {11'd0, de_rise} : de_rise ? sat_inc(va_cnt_q) : va_cnt_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cap_req) state_d = ARMED;
            ARMED:   if (vs_fall) state_d = CAPTURE;
            CAPTURE: if (vs_fall) state_d = DONE;
            default: state_d = IDLE;
        endcase
        in_frame   = (state_q == ARMED && vs_fall) || (state_q == CAPTURE && !vs_fall);
        in_bounds  = pix_col < 12'(MAX_W) && pix_row < 12'(MAX_H);
        wr_en_d    = in_frame && de_q && in_bounds;
        wr_addr_d  = ADDR_W'(32'(pix_row) * MAX_W + 32'(pix_col));
        overflow_d = (state_q == IDLE && cap_req) ? 1'b0 : overflow_q | (in_frame && de_q && !in_bounds);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            hs_q           <= 1'b1;
            vs_q           <= 1'b1;
            de_q           <= 1'b0;
            hs_p_q         <= 1'b1;
            vs_p_q         <= 1'b1;
            de_p_q         <= 1'b0;
            rgb_q          <= '0;
            col_q          <= '0;
            row_q          <= '0;
            h_cnt_q        <= '0;
            h_tot_q        <= '0;
            h_act_q        <= '0;
            v_cnt_q        <= '0;
            va_cnt_q       <= '0;
            seen_vs_q      <= 1'b0;
            meas_valid_q   <= 1'b0;
            meas_h_total_q <= '0;
            meas_h_act_q   <= '0;
            meas_v_total_q <= '0;
            meas_v_act_q   <= '0;
            overflow_q     <= 1'b0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
        end else begin
            state_q    <= state_d;
            hs_q       <= vid_hs;
            vs_q       <= vid_vs;
            de_q       <= vid_de;
            hs_p_q     <= hs_q;
            vs_p_q     <= vs_q;
            de_p_q     <= de_q;
            rgb_q      <= vid_rgb;
            col_q      <= col_d;
            row_q      <= row_d;
            h_cnt_q    <= h_cnt_d;
            h_tot_q    <= h_tot_d;
            h_act_q    <= h_act_d;
            v_cnt_q    <= v_cnt_d;
            va_cnt_q   <= va_cnt_d;
            overflow_q <= overflow_d;
            wr_en_q    <= wr_en_d;
            if (wr_en_d) begin
                wr_addr_q <= wr_addr_d;
                wr_data_q <= rgb_q;
            end
            if (vs_fall) begin
                seen_vs_q      <= 1'b1;
                meas_valid_q   <= meas_valid_q | seen_vs_q;
                meas_h_total_q <= h_tot_d;
                meas_h_act_q   <= h_act_d;
                meas_v_total_q <= v_cnt_q;
                meas_v_act_q   <= va_cnt_q;
            end
        end
    end

`ifdef VGA_CAP_CHECKSUM_EN
    logic [31:0] sum_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            sum_q <= '0;
        else if (state_q == IDLE && cap_req)
            sum_q <= '0;
        else if (wr_en_d)
            sum_q <= sum_q + {8'd0, rgb_q};
    end
    assign cap_sum = sum_q;
`endif

    assign cap_busy     = state_q == ARMED || state_q == CAPTURE;
    assign cap_done     = state_q == DONE;
    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign meas_valid   = meas_valid_q;
    assign meas_h_total = meas_h_total_q;
    assign meas_h_act   = meas_h_act_q;
    assign meas_v_total = meas_v_total_q;
    assign meas_v_act   = meas_v_act_q;
    assign overflow     = overflow_q;
endmodule

// File: tb/tb_vga_frame_capture.sv
// tb_vga_frame_capture: directed bench for vga_frame_capture on a scaled-down 8x6 frame.
module tb_vga_frame_capture;
    localparam int MW = 8, MH = 6, AW = 6;
    logic clk = 1'b0, reset_n = 1'b0;
    logic vid_hs, vid_vs, vid_de, cap_req = 1'b0;
    logic [23:0] vid_rgb;
    logic cap_busy, cap_done, wr_en, meas_valid, overflow;
    logic [AW-1:0] wr_addr;
    logic [23:0] wr_data;
    logic [11:0] meas_h_total, meas_h_act, meas_v_total, meas_v_act;
`ifdef VGA_CAP_CHECKSUM_EN
    logic [31:0] cap_sum;
`endif
    int checks = 0, fails = 0;
    int h_tot = 14, h_act = 8, v_tot = 10, v_act = 6;
    bit on = 1'b0;
    int nwr, ord_err, dat_err, ndone, seen_tag, arm_tag;
    logic [AW-1:0] last_addr;

    vga_frame_capture #(.MAX_W(MW), .MAX_H(MH), .ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n), .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_de(vid_de),
        .vid_rgb(vid_rgb), .cap_req(cap_req), .cap_busy(cap_busy), .cap_done(cap_done),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .meas_valid(meas_valid),
        .meas_h_total(meas_h_total), .meas_h_act(meas_h_act), .meas_v_total(meas_v_total),
        .meas_v_act(meas_v_act),
`ifdef VGA_CAP_CHECKSUM_EN
        .cap_sum(cap_sum),
`endif
        .overflow(overflow));

    always #5 clk = ~clk;

    // Video source: DE first in each line, HS low 2 clks after it, VS low for 2 whole lines.
    initial begin
        vid_hs = 1'b1; vid_vs = 1'b1; vid_de = 1'b0; vid_rgb = '0;
        forever
            for (int y = 0; y < v_tot; y++)
                for (int x = 0; x < h_tot; x++) begin
                    @(posedge clk); #1;
                    vid_de  = on && x < h_act && y < v_act;
                    vid_rgb = vid_de ? 24'(y * MW + x) : 24'd0;
                    vid_hs  = !(on && x >= h_act + 1 && x < h_act + 3);
                    vid_vs  = !(on && y >= v_act + 1 && y < v_act + 3);
                end
    end

    // Write monitor; counters restart whenever the main sequence arms a new capture.
    always @(negedge clk) begin
        if (seen_tag != arm_tag) begin
            seen_tag = arm_tag; nwr = 0; ord_err = 0; dat_err = 0; ndone = 0;
        end
        if (wr_en === 1'b1) begin
            if (wr_addr !== AW'(nwr)) ord_err++;
            if (wr_data !== 24'(wr_addr)) dat_err++;
            last_addr = wr_addr;
            nwr++;
        end
        if (cap_done === 1'b1) ndone++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_req(input bit bump);
        @(posedge clk); #1;
        if (bump) arm_tag++;
        cap_req = 1'b1;
        @(posedge clk); #1;
        cap_req = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int n);
        for (int i = 0; i < n && cap_done !== 1'b1; i++) @(negedge clk);
        chk(tag, 32'(cap_done), 1);
        repeat (5) @(negedge clk);
        @(posedge clk);
    endtask

    task automatic check_frame(input string tag, input logic ovf);
        chk({tag, "_writes"}, nwr, MW * MH);
        chk({tag, "_last"}, 32'(last_addr), MW * MH - 1);
        chk({tag, "_order"}, ord_err, 0);
        chk({tag, "_data"}, dat_err, 0);
        chk({tag, "_ndone"}, ndone, 1);
        chk({tag, "_ovf"}, 32'(overflow), 32'(ovf));
        chk({tag, "_idle"}, 32'(cap_busy), 0);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_busy", 32'(cap_busy), 0);
        chk("rst_done", 32'(cap_done), 0);
        chk("rst_valid", 32'(meas_valid), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_htot", 32'(meas_h_total), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        on = 1'b1;
        repeat (460) @(negedge clk);
        chk("meas_h_total", 32'(meas_h_total), 14);
        chk("meas_h_act", 32'(meas_h_act), 8);
        chk("meas_v_total", 32'(meas_v_total), 10);
        chk("meas_v_act", 32'(meas_v_act), 6);
        chk("meas_valid", 32'(meas_valid), 1);

        repeat (37) @(negedge clk);
        pulse_req(1'b1);
        @(negedge clk);
        chk("armed_busy", 32'(cap_busy), 1);
        wait_done("cap1_done", 400);
        check_frame("cap1", 1'b0);

        h_tot = 16; h_act = 10; v_tot = 12; v_act = 8;
        repeat (650) @(negedge clk);
        chk("clip_h_act", 32'(meas_h_act), 10);
        chk("clip_v_act", 32'(meas_v_act), 8);
        chk("clip_h_total", 32'(meas_h_total), 16);
        chk("clip_v_total", 32'(meas_v_total), 12);
        pulse_req(1'b1);
        wait_done("clip_done", 600);
        check_frame("clip", 1'b1);

        h_tot = 14; h_act = 8; v_tot = 10; v_act = 6;
        repeat (500) @(negedge clk);
        pulse_req(1'b1);
        for (int i = 0; i < 400 && wr_en !== 1'b1; i++) @(negedge clk);
        chk("ign_in_capture", 32'(wr_en), 1);
        pulse_req(1'b0);
        wait_done("ign_done", 300);
        check_frame("ign", 1'b0);
        repeat (300) @(negedge clk);
        chk("ign_no_redo", ndone, 1);

        on = 1'b0;
        repeat (300) @(negedge clk);
        pulse_req(1'b1);
        repeat (300) @(negedge clk);
        chk("novid_busy", 32'(cap_busy), 1);
        chk("novid_writes", nwr, 0);
        chk("novid_done", ndone, 0);
        pulse_req(1'b0);
        repeat (20) @(negedge clk);
        chk("novid_busy2", 32'(cap_busy), 1);

        on = 1'b1;
        for (int i = 0; i < 1000 && nwr < 20; i++) @(negedge clk);
        chk("mid_progress", 32'(nwr >= 20), 1);
        for (int i = 0; i < 50 && wr_en !== 1'b1; i++) @(negedge clk);
        chk("mid_wr_en", 32'(wr_en), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_wr_en", 32'(wr_en), 0);
        chk("arst_busy", 32'(cap_busy), 0);
        chk("arst_addr", 32'(wr_addr), 0);
        chk("arst_valid", 32'(meas_valid), 0);
        chk("arst_htot", 32'(meas_h_total), 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (300) @(negedge clk);
        chk("arst_no_done", ndone, 0);
        chk("arst_idle", 32'(cap_busy), 0);
        pulse_req(1'b1);
        wait_done("post_done", 400);
        check_frame("post", 1'b0);
`ifdef VGA_CAP_CHECKSUM_EN
        chk("cap_sum", cap_sum, 1128);
`endif
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
